// File: rtl/melody_sequencer.sv
// Melody sequencer: walks a fixed note table, playing each entry for a
// programmable number of ticks and inserting a silent gap between entries.
//
// state  | meaning
// IDLE   | waiting for start, outputs quiet
// LOAD   | one cycle to fetch the table entry at step
// PLAY   | note sounding (rests are timed but silent)
// GAP    | silent gap after a note
// DONE   | one-cycle completion pulse, then IDLE
module melody_sequencer #(
    parameter int TICK_CYCLES = 100000,
    parameter int NOTE_TICKS  = 250,
    parameter int GAP_TICKS   = 20,
    parameter int SONG_LEN    = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       loop_en,
    output logic [3:0] note_idx,
    output logic       tone_en,
    output logic [3:0] step,
    output logic       busy,
    output logic       done
);

    localparam int PW       = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int PLAY_MAX = 4 * NOTE_TICKS;
    localparam int T_MAX    = (PLAY_MAX > GAP_TICKS) ? PLAY_MAX : GAP_TICKS;
    localparam int TW       = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_PLAY,
        S_GAP,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      step_q, step_d;
    logic [3:0]      note_q, note_d;
    logic [1:0]      dur_q, dur_d;
    logic            tone_q, tone_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            wrap_q, wrap_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [TW-1:0]   tick_q, tick_d;

    logic [3:0]      rom_note;
    logic [1:0]      rom_dur;
    logic [3:0]      step_nx;
    logic            wrap_nx;
    logic [TW-1:0]   tgt_m1;
    logic            presc_last;
    logic            expire;
    logic            is_end;

    // Melody table, entries are {note code, duration code}; note F ends the song
    always_comb begin
        rom_note = 4'hF;
        rom_dur  = 2'd0;
        case (step_q)
            4'd0: begin rom_note = 4'h1; rom_dur = 2'd0; end
            4'd1: begin rom_note = 4'h3; rom_dur = 2'd1; end
            4'd2: begin rom_note = 4'h0; rom_dur = 2'd0; end
            4'd3: begin rom_note = 4'h5; rom_dur = 2'd3; end
            default: begin rom_note = 4'hF; rom_dur = 2'd0; end
        endcase
    end

    // Step advance; running off the end of the table counts as an end marker
    always_comb begin
        if (step_q == 4'(SONG_LEN - 1)) begin
            step_nx = 4'd0;
            wrap_nx = 1'b1;
        end else begin
            step_nx = step_q + 4'd1;
            wrap_nx = 1'b0;
        end
    end

    // Duration compare: the current state expires on the last cycle of its last tick
    always_comb begin
        if (state_q == S_GAP) begin
            tgt_m1 = TW'(GAP_TICKS - 1);
        end else begin
            tgt_m1 = TW'((int'(dur_q) + 1) * NOTE_TICKS - 1);
        end
        presc_last = (presc_q == PW'(TICK_CYCLES - 1));
        expire     = presc_last && (tick_q == tgt_m1);
        is_end     = (rom_note == 4'hF) || wrap_q;
    end

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        note_d  = note_q;
        dur_d   = dur_q;
        tone_d  = tone_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        wrap_d  = wrap_q;
        presc_d = '0;
        tick_d  = '0;

        if (stop) begin
            state_d = S_IDLE;
            note_d  = 4'd0;
            tone_d  = 1'b0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    note_d = 4'd0;
                    tone_d = 1'b0;
                    busy_d = 1'b0;
                    if (start) begin
                        step_d  = 4'd0;
                        wrap_d  = 1'b0;
                        busy_d  = 1'b1;
                        state_d = S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (!is_end) begin
                        note_d  = rom_note;
                        dur_d   = rom_dur;
                        tone_d  = (rom_note != 4'd0);
                        state_d = S_PLAY;
                    end else if (loop_en && ((step_q != 4'd0) || wrap_q)) begin
                        step_d = 4'd0;
                        wrap_d = 1'b0;
                    end else begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end
                S_PLAY: begin
                    if (expire) begin
                        note_d = 4'd0;
                        tone_d = 1'b0;
                        if (GAP_TICKS > 0) begin
                            state_d = S_GAP;
                        end else begin
                            step_d  = step_nx;
                            wrap_d  = wrap_nx;
                            state_d = S_LOAD;
                        end
                    end else begin
                        presc_d = presc_last ? '0 : presc_q + PW'(1);
                        tick_d  = presc_last ? tick_q + TW'(1) : tick_q;
                    end
                end
                S_GAP: begin
                    if (expire) begin
                        step_d  = step_nx;
                        wrap_d  = wrap_nx;
                        state_d = S_LOAD;
                    end else begin
                        presc_d = presc_last ? '0 : presc_q + PW'(1);
                        tick_d  = presc_last ? tick_q + TW'(1) : tick_q;
                    end
                end
                S_DONE: begin
                    busy_d  = 1'b0;
                    tone_d  = 1'b0;
                    note_d  = 4'd0;
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    tone_d  = 1'b0;
                    note_d  = 4'd0;
                end
            endcase
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            step_q  <= 4'd0;
            note_q  <= 4'd0;
            dur_q   <= 2'd0;
            tone_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
            presc_q <= '0;
            tick_q  <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            note_q  <= note_d;
            dur_q   <= dur_d;
            tone_q  <= tone_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            wrap_q  <= wrap_d;
            presc_q <= presc_d;
            tick_q  <= tick_d;
        end
    end

    assign note_idx = note_q;
    assign tone_en  = tone_q;
    assign step     = step_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Bench for melody_sequencer: two instances (gap of 1 tick and no gap) share
// all inputs and are compared every cycle against per-cycle timelines that
// are expanded from the note table.
module tb_melody_sequencer;

    localparam int TC   = 10;
    localparam int NT   = 2;
    localparam logic [10:0] STEP_MASK = 11'b000_0011_1100;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       stop;
    logic       loop_en;
    logic [3:0] note1, step1, note0, step0;
    logic       tone1, busy1, done1, tone0, busy0, done0;

    int n_chk  = 0;
    int n_fail = 0;

    int tnote [16];
    int tdur  [16];

    logic [10:0] scratch [$];
    logic [10:0] q1 [$];
    logic [10:0] q0 [$];

    always #5 clk = ~clk;

    melody_sequencer #(.TICK_CYCLES(TC), .NOTE_TICKS(NT), .GAP_TICKS(1), .SONG_LEN(16)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .loop_en(loop_en),
        .note_idx(note1), .tone_en(tone1), .step(step1), .busy(busy1), .done(done1));

    melody_sequencer #(.TICK_CYCLES(TC), .NOTE_TICKS(NT), .GAP_TICKS(0), .SONG_LEN(16)) dut_nogap (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .loop_en(loop_en),
        .note_idx(note0), .tone_en(tone0), .step(step0), .busy(busy0), .done(done0));

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got 0x%0h, want 0x%0h", tag, $time, obs, exp);
        end
    endtask

    // {note, tone, step, busy, done}
    function automatic logic [10:0] pk(input int n, input bit t, input int s, input bit b, input bit d);
        return {4'(n), t, 4'(s), b, d};
    endfunction

    function automatic logic [10:0] obs1();
        return {note1, tone1, step1, busy1, done1};
    endfunction

    function automatic logic [10:0] obs0();
        return {note0, tone0, step0, busy0, done0};
    endfunction

    // Expand the table into the expected per-cycle output timeline after the start edge
    task automatic build(input int gap, input bit lp);
        int s;
        s = 0;
        scratch.delete();
        while (scratch.size() < 1500) begin
            if (tnote[s] != 15) begin
                scratch.push_back(pk(0, 0, s, 1, 0));
                repeat ((tdur[s] + 1) * NT * TC) scratch.push_back(pk(tnote[s], tnote[s] != 0, s, 1, 0));
                repeat (gap * TC) scratch.push_back(pk(0, 0, s, 1, 0));
                s = (s + 1) % 16;
            end else begin
                scratch.push_back(pk(0, 0, s, 1, 0));
                if (lp && s != 0) begin
                    s = 0;
                end else begin
                    scratch.push_back(pk(0, 0, s, 0, 1));
                    scratch.push_back(pk(0, 0, s, 0, 0));
                    break;
                end
            end
        end
    endtask

    function automatic int count_bit(input int which, input int bitpos);
        int c;
        c = 0;
        if (which == 1) begin
            foreach (q1[k]) c += int'(q1[k][bitpos]);
        end else begin
            foreach (q0[k]) c += int'(q0[k][bitpos]);
        end
        return c;
    endfunction

    // Start a song and compare every cycle; optional stop, mid-song start poke, or reset
    task automatic play(input bit lp, input int ncyc, input int stop_at, input int poke_at,
                        input int reset_at, input bit full);
        logic [10:0] e1, e0, p1, p0;
        int b1, b0, d1, d0, n;
        bit stopped;
        b1 = 0; b0 = 0; d1 = 0; d0 = 0; stopped = 0;
        p1 = '0; p0 = '0;
        build(1, lp); q1 = scratch;
        build(0, lp); q0 = scratch;
        n = (ncyc < 0) ? q1.size() + 3 : ncyc;
        loop_en = lp;
        stop    = 1'b0;
        start   = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            stop  = 1'b0;
            if (stop_at >= 0 && i == stop_at + 1) stopped = 1;
            if (stopped) begin
                e1 = p1 & STEP_MASK;
                e0 = p0 & STEP_MASK;
            end else begin
                e1 = (i < q1.size()) ? q1[i] : q1[q1.size() - 1];
                e0 = (i < q0.size()) ? q0[i] : q0[q0.size() - 1];
            end
            check_eq("out_gap1", 32'(obs1()), 32'(e1));
            check_eq("out_gap0", 32'(obs0()), 32'(e0));
            p1 = e1;
            p0 = e0;
            b1 += int'(busy1);
            b0 += int'(busy0);
            d1 += int'(done1);
            d0 += int'(done0);
            if (i == stop_at) stop = 1'b1;
            if (i == poke_at) start = 1'b1;
            if (i == reset_at) begin
                reset = 1'b1;
                #1;
                check_eq("async_rst_gap1", 32'(obs1()), 32'd0);
                check_eq("async_rst_gap0", 32'(obs0()), 32'd0);
                @(posedge clk);
                #1;
                check_eq("rst_hold_gap1", 32'(obs1()), 32'd0);
                check_eq("rst_hold_gap0", 32'(obs0()), 32'd0);
                reset = 1'b0;
                start = 1'b0;
                return;
            end
        end
        start = 1'b0;
        stop  = 1'b0;
        if (full) begin
            check_eq("busy_len_gap1", 32'(b1), 32'd205);
            check_eq("busy_len_gap1_model", 32'(b1), 32'(count_bit(1, 1)));
            check_eq("busy_len_gap0", 32'(b0), 32'(count_bit(0, 1)));
            check_eq("done_cnt_gap1", 32'(d1), 32'd1);
            check_eq("done_cnt_gap0", 32'(d0), 32'd1);
            check_eq("end_step_gap1", 32'(step1), 32'd4);
        end
        if (stop_at >= 0) begin
            check_eq("no_done_gap1", 32'(d1), 32'd0);
            check_eq("no_done_gap0", 32'(d0), 32'd0);
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 16; k++) begin
            tnote[k] = 15;
            tdur[k]  = 0;
        end
        tnote[0] = 1; tdur[0] = 0;
        tnote[1] = 3; tdur[1] = 1;
        tnote[2] = 0; tdur[2] = 0;
        tnote[3] = 5; tdur[3] = 3;

        reset   = 1'b1;
        start   = 1'b0;
        stop    = 1'b0;
        loop_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_gap1", 32'(obs1()), 32'd0);
        check_eq("reset_gap0", 32'(obs0()), 32'd0);
        reset = 1'b0;
        idle_cycles(2);

        // stop wins over start in the same idle cycle
        start = 1'b1;
        stop  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        stop  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_eq("collide_gap1", 32'(obs1()), 32'd0);
            check_eq("collide_gap0", 32'(obs0()), 32'd0);
            @(posedge clk);
            #1;
        end

        // full song, no loop
        play(1'b0, -1, -1, -1, -1, 1'b1);
        idle_cycles($urandom_range(1, 5));

        // start poked during step 1 of the gapped instance
        play(1'b0, -1, -1, $urandom_range(32, 70), -1, 1'b1);
        idle_cycles($urandom_range(1, 5));

        // loop with a random stop after at least one wrap
        play(1'b1, 700, $urandom_range(230, 600), -1, -1, 1'b0);
        idle_cycles($urandom_range(1, 5));

        // async reset during step 3 of the gapped instance
        play(1'b0, 300, -1, -1, $urandom_range(120, 185), 1'b0);
        idle_cycles($urandom_range(1, 5));

        // clean replay after reset
        play(1'b0, -1, -1, -1, -1, 1'b1);
        idle_cycles(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
